// File: rtl/pwm_pkg.sv
// Shared PWM definitions: compare-function encodings and the default counter
// width. The register file, period counter and compare stage all use these.
package pwm_pkg;

   localparam int CNT_W_DEF = 16;

   // functions[1]: 0 = aligned, 1 = unaligned
   // functions[0]: 0 = left, 1 = right (aligned only)
   localparam logic [1:0] FUNC_ALIGN_LEFT  = 2'b00;
   localparam logic [1:0] FUNC_ALIGN_RIGHT = 2'b01;
   localparam logic [1:0] FUNC_UNALIGNED   = 2'b10;

endpackage

// File: rtl/pwm_shadow_regs.sv
// Active compare-register bank with period-boundary and load detection.
// Ports:
//   clk, rst            clock, async active-high reset
//   count_val, period   counter value and period (period is the down-count
//                       wrap target)
//   upnotdown           counter direction, 1 = up
//   pwm_en              output enable; its rising edge forces a load
//   compare1/2, functions  shadow (register-file) values
//   bnd                 first cycle the counter shows its wrapped value
//   cmp1_eff/cmp2_eff/func_eff  values to use this cycle (shadow on a load)
//   active_cmp1         committed compare1 for readback
module pwm_shadow_regs
   import pwm_pkg::*;
#(
   parameter int CNT_W = CNT_W_DEF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [CNT_W-1:0] count_val,
   input  logic [CNT_W-1:0] period,
   input  logic             upnotdown,
   input  logic             pwm_en,
   input  logic [CNT_W-1:0] compare1,
   input  logic [CNT_W-1:0] compare2,
   input  logic [1:0]       functions,
   output logic             bnd,
   output logic [CNT_W-1:0] cmp1_eff,
   output logic [CNT_W-1:0] cmp2_eff,
   output logic [1:0]       func_eff,
   output logic [CNT_W-1:0] active_cmp1
);

   logic [CNT_W-1:0] cmp1_q;
   logic [CNT_W-1:0] cmp2_q;
   logic [1:0]       func_q;
   logic [CNT_W-1:0] cnt_prev;
   logic             en_prev;
   logic [CNT_W-1:0] bnd_target;
   logic             ld;

   // A counter stalled by its prescaler repeats count_val; the change test
   // keeps a held wrap value from producing more than one boundary.
   always_comb begin
      bnd_target = upnotdown ? '0 : period;
      bnd        = pwm_en & (count_val != cnt_prev) & (count_val == bnd_target);
      ld         = bnd | (pwm_en & ~en_prev);
      // The shadow values are applied in the load cycle itself, so a new
      // period's settings govern its very first count.
      cmp1_eff   = ld ? compare1  : cmp1_q;
      cmp2_eff   = ld ? compare2  : cmp2_q;
      func_eff   = ld ? functions : func_q;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cmp1_q   <= '0;
         cmp2_q   <= '0;
         func_q   <= '0;
         cnt_prev <= '0;
         en_prev  <= 1'b0;
      end else begin
         cnt_prev <= count_val;
         en_prev  <= pwm_en;
         if (ld) begin
            cmp1_q <= compare1;
            cmp2_q <= compare2;
            func_q <= functions;
         end
      end
   end

   assign active_cmp1 = cmp1_q;

endmodule

// File: rtl/pwm_compare_gen.sv
// PWM compare stage: turns the period counter's count_val into a registered
// PWM waveform using shadowed compare values committed at period boundaries.
// Ports:
//   clk, rst            clock, async active-high reset
//   count_val, period, upnotdown  period counter state
//   pwm_en              output enable (0 forces pwm_out low)
//   compare1, compare2, functions shadow register-file values
//   pwm_out             registered PWM output
//   period_tick         one-cycle pulse after each committed boundary
//   active_cmp1         committed compare1 for readback
module pwm_compare_gen
   import pwm_pkg::*;
#(
   parameter int CNT_W = CNT_W_DEF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [CNT_W-1:0] count_val,
   input  logic [CNT_W-1:0] period,
   input  logic             upnotdown,
   input  logic             pwm_en,
   input  logic [CNT_W-1:0] compare1,
   input  logic [CNT_W-1:0] compare2,
   input  logic [1:0]       functions,
   output logic             pwm_out,
   output logic             period_tick,
   output logic [CNT_W-1:0] active_cmp1
);

   logic             bnd;
   logic [CNT_W-1:0] cmp1_eff;
   logic [CNT_W-1:0] cmp2_eff;
   logic [1:0]       func_eff;
   logic             pwm_next;

   pwm_shadow_regs #(.CNT_W(CNT_W)) u_shadow (
      .clk         (clk),
      .rst         (rst),
      .count_val   (count_val),
      .period      (period),
      .upnotdown   (upnotdown),
      .pwm_en      (pwm_en),
      .compare1    (compare1),
      .compare2    (compare2),
      .functions   (functions),
      .bnd         (bnd),
      .cmp1_eff    (cmp1_eff),
      .cmp2_eff    (cmp2_eff),
      .func_eff    (func_eff),
      .active_cmp1 (active_cmp1)
   );

   // Plain unsigned compares: E1=0 gives always-low (left) / always-high
   // (right); E1 >= E2 gives an empty unaligned window.
   always_comb begin
      pwm_next = 1'b0;
      case (func_eff)
         FUNC_ALIGN_LEFT:  pwm_next = (count_val < cmp1_eff);
         FUNC_ALIGN_RIGHT: pwm_next = (count_val >= cmp1_eff);
         default:          pwm_next = (count_val >= cmp1_eff) && (count_val < cmp2_eff);
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pwm_out     <= 1'b0;
         period_tick <= 1'b0;
      end else begin
         pwm_out     <= pwm_en & pwm_next;
         period_tick <= bnd;
      end
   end

endmodule
